// File: rtl/viterbi_acs_scheduler_pkg.sv
// Shared types and constants for the 4-state Viterbi add-compare-select scheduler.
package viterbi_acs_scheduler_pkg;
    localparam int MW      = 8;
    localparam int DW      = 4;
    localparam int NSTATES = 4;

    typedef logic signed [MW-1:0] metric_t;
    typedef logic [DW-1:0]        dec_t;

    localparam metric_t PM_INIT_ZERO   = '0;
    localparam metric_t PM_INIT_THRESH = 8'sd64;

    typedef enum logic [2:0] {
        IDLE, ACCEPT, ISSUE_TOP, ISSUE_BOT, WAIT, NORM, TRACE, EMIT
    } acs_state_t;

    // Index of the smallest metric; strict compare keeps the lowest index on ties.
    function automatic logic [1:0] pm_argmin(metric_t m0, metric_t m1, metric_t m2, metric_t m3);
        logic [1:0] idx;
        metric_t    best;
        idx  = 2'd0;
        best = m0;
        if (m1 < best) begin idx = 2'd1; best = m1; end
        if (m2 < best) begin idx = 2'd2; best = m2; end
        if (m3 < best) begin idx = 2'd3; end
        return idx;
    endfunction
endpackage

// File: rtl/viterbi_surv_mem.sv
// Survivor decision store: one 4-bit decision word per trellis step.
// Writes land on the clock edge; reads are combinational so traceback walks one step per cycle.
module viterbi_surv_mem
    import viterbi_acs_scheduler_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  dec_t          wdata,
    input  logic [AW-1:0] raddr,
    output dec_t          rdata
);
    dec_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/viterbi_acs_scheduler.sv
// Sequences one symbol pair per trellis step through an external butterfly, normalises metrics,
// traces back at frame end and streams decoded bits; input stalls while a step or frame is in flight.
module viterbi_acs_scheduler
    import viterbi_acs_scheduler_pkg::*;
#(
    parameter int      FRAME_MAX   = 16,
    parameter int      BFLY_LAT    = 2,
    parameter metric_t NORM_THRESH = PM_INIT_THRESH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [MW-1:0] in_r3,
    input  logic signed [MW-1:0] in_r4,
    input  logic                 in_last,
    output logic                 bfly_issue,
    output logic                 bfly_sel,
    output logic signed [MW-1:0] bfly_r3,
    output logic signed [MW-1:0] bfly_r4,
    output logic signed [MW-1:0] bfly_edge_a,
    output logic signed [MW-1:0] bfly_edge_b,
    input  logic signed [MW-1:0] bfly_surv_a,
    input  logic signed [MW-1:0] bfly_surv_b,
    input  logic [DW-1:0]        bfly_dec_a,
    input  logic [DW-1:0]        bfly_dec_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_bit,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overflow_err
);
    localparam int              KW     = $clog2(FRAME_MAX);
    localparam int              WW     = $clog2(BFLY_LAT + 2);
    localparam logic [KW-1:0]   K_LAST = KW'(FRAME_MAX - 1);
    localparam logic [WW-1:0]   W_TOP  = WW'(BFLY_LAT);
    localparam logic [WW-1:0]   W_BOT  = WW'(BFLY_LAT + 1);

    acs_state_t           state;
    metric_t              pm [NSTATES];
    metric_t              pm_top0, pm_top2;
    logic [1:0]           dec_top;
    logic [KW-1:0]        k, tk, ecnt;
    logic [WW-1:0]        wcnt;
    logic                 sym_last;
    logic [1:0]           s;
    logic [FRAME_MAX-1:0] fbuf;
    logic                 mem_we, all_high, unused_dec;
    dec_t                 mem_wdata, mem_rdata;

    // Top decisions are held until the bottom result arrives so the word is written once.
    assign mem_we     = (state == WAIT) && (wcnt == W_BOT);
    assign mem_wdata  = {bfly_dec_b[3], dec_top[1], bfly_dec_a[3], dec_top[0]};
    assign all_high   = (pm[0] >= NORM_THRESH) && (pm[1] >= NORM_THRESH) &&
                        (pm[2] >= NORM_THRESH) && (pm[3] >= NORM_THRESH);
    assign unused_dec = ^{bfly_dec_a[2:0], bfly_dec_b[2:0]};

    viterbi_surv_mem #(.DEPTH(FRAME_MAX), .AW(KW)) u_surv_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (k),
        .wdata (mem_wdata),
        .raddr (tk),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            k            <= '0;
            tk           <= '0;
            ecnt         <= '0;
            wcnt         <= '0;
            sym_last     <= 1'b0;
            s            <= '0;
            fbuf         <= '0;
            pm[0]        <= PM_INIT_ZERO;
            pm[1]        <= NORM_THRESH;
            pm[2]        <= NORM_THRESH;
            pm[3]        <= NORM_THRESH;
            pm_top0      <= '0;
            pm_top2      <= '0;
            dec_top      <= '0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
            overflow_err <= 1'b0;
            bfly_issue   <= 1'b0;
            bfly_sel     <= 1'b0;
            bfly_r3      <= '0;
            bfly_r4      <= '0;
            bfly_edge_a  <= '0;
            bfly_edge_b  <= '0;
            out_valid    <= 1'b0;
            out_bit      <= 1'b0;
            out_last     <= 1'b0;
        end else begin
            // With short latency the top result can land while the bottom issue is still out.
            if ((state == ISSUE_BOT || state == WAIT) && wcnt == W_TOP) begin
                pm_top0 <= bfly_surv_a;
                pm_top2 <= bfly_surv_b;
                dec_top <= {bfly_dec_b[3], bfly_dec_a[3]};
            end
            case (state)
                IDLE, ACCEPT: begin
                    if (in_valid) begin
                        bfly_r3    <= in_r3;
                        bfly_r4    <= in_r4;
                        sym_last   <= in_last;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        bfly_issue <= 1'b1;
                        bfly_sel   <= 1'b0;
                        wcnt       <= '0;
                        state      <= ISSUE_TOP;
                        if (state == IDLE) begin
                            k           <= '0;
                            pm[0]       <= PM_INIT_ZERO;
                            pm[1]       <= NORM_THRESH;
                            pm[2]       <= NORM_THRESH;
                            pm[3]       <= NORM_THRESH;
                            bfly_edge_a <= PM_INIT_ZERO;
                            bfly_edge_b <= NORM_THRESH;
                        end else begin
                            bfly_edge_a <= pm[0];
                            bfly_edge_b <= pm[1];
                        end
                    end
                end
                ISSUE_TOP: begin
                    bfly_sel    <= 1'b1;
                    bfly_edge_a <= pm[2];
                    bfly_edge_b <= pm[3];
                    wcnt        <= wcnt + 1'b1;
                    state       <= ISSUE_BOT;
                end
                ISSUE_BOT: begin
                    bfly_issue <= 1'b0;
                    bfly_sel   <= 1'b0;
                    wcnt       <= wcnt + 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == W_BOT) begin
                        pm[0] <= pm_top0;
                        pm[1] <= bfly_surv_a;
                        pm[2] <= pm_top2;
                        pm[3] <= bfly_surv_b;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (all_high) begin
                        for (int i = 0; i < NSTATES; i++) pm[i] <= pm[i] - NORM_THRESH;
                    end
                    // A uniform subtraction cannot move the minimum, so pick the start state now.
                    s <= pm_argmin(pm[0], pm[1], pm[2], pm[3]);
                    if (sym_last || k == K_LAST) begin
                        if (!sym_last) overflow_err <= 1'b1;
                        tk    <= k;
                        state <= TRACE;
                    end else begin
                        k        <= k + 1'b1;
                        in_ready <= 1'b1;
                        state    <= ACCEPT;
                    end
                end
                TRACE: begin
                    fbuf[tk] <= s[1];
                    s        <= {s[0], mem_rdata[s]};
                    if (tk == '0) begin
                        out_valid <= 1'b1;
                        out_bit   <= s[1];
                        out_last  <= (k == '0);
                        ecnt      <= '0;
                        state     <= EMIT;
                    end else begin
                        tk <= tk - 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (ecnt == k) begin
                            out_valid <= 1'b0;
                            out_bit   <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            ecnt     <= ecnt + 1'b1;
                            out_bit  <= fbuf[ecnt + 1'b1];
                            out_last <= ((ecnt + 1'b1) == k);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
